// File: rtl/indicator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : indicator_pkg
//  Description : Shared constants for the indicator scanner and its decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package indicator_pkg;

    localparam int SEG_WIDTH = 7;
    localparam logic [SEG_WIDTH-1:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; entry 15 is the most significant slice.
    localparam logic [15:0][SEG_WIDTH-1:0] c_SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage
`default_nettype wire

// File: rtl/indicator_scanner_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seven_seg_decoder
//  Description : Combinational hex digit to active-low seven-segment lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_decoder
    import indicator_pkg::*;
(
    input  logic [3:0]           i_digit,
    output logic [SEG_WIDTH-1:0] o_segments
);

    assign o_segments = c_SEG_TABLE[i_digit];

endmodule
`default_nettype wire

// File: rtl/indicator_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : indicator_scanner
//  Description : Addressable digit registers with flat readback and a
//                time-multiplexed active-low seven-segment display driver.
//  Revision    : 1.0 - initial release
// ============================================================================
module indicator_scanner
    import indicator_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int DATA_WIDTH = 4,
    parameter int PORT_WIDTH = 2,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         rw,
    input  logic [DATA_WIDTH-1:0]        data,
    input  logic [PORT_WIDTH-1:0]        port_id,
    input  logic                         blank_lz,
    output logic [DIGITS*DATA_WIDTH-1:0] indicator,
    output logic [DIGITS-1:0]            anode,
    output logic [SEG_WIDTH-1:0]         segments
);

    localparam int c_PRESC_W = $clog2(SCAN_DIV);
    localparam int c_IDX_W   = $clog2(DIGITS);
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(SCAN_DIV - 1);
    localparam logic [c_IDX_W-1:0]   c_IDX_MAX   = c_IDX_W'(DIGITS - 1);

    logic [DIGITS-1:0][DATA_WIDTH-1:0] r_digits;
    logic [c_PRESC_W-1:0]              r_presc;
    logic [c_IDX_W-1:0]                r_index;
    logic [DIGITS-1:0]                 r_anode;
    logic [SEG_WIDTH-1:0]              r_segments;

    logic                  w_tick;
    logic                  w_wr_en;
    logic [c_IDX_W-1:0]    w_wr_idx;
    logic [DIGITS-1:0]     w_blank;
    logic [SEG_WIDTH-1:0]  w_dec_seg;

    assign w_tick   = (r_presc == c_PRESC_MAX);
    assign w_wr_en  = rw && (32'(port_id) < DIGITS);
    assign w_wr_idx = port_id[c_IDX_W-1:0];

    // A digit is blanked when it and every digit above it are zero; digit 0 never.
    always_comb begin
        logic w_zero_above;
        w_blank      = '0;
        w_zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_zero_above = w_zero_above && (r_digits[k][3:0] == 4'h0);
            w_blank[k]   = blank_lz && w_zero_above;
        end
    end

    seven_seg_decoder u_decoder (
        .i_digit    (r_digits[r_index][3:0]),
        .o_segments (w_dec_seg)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_digits   <= '0;
            r_presc    <= '0;
            r_index    <= '0;
            r_anode    <= '1;
            r_segments <= SEG_BLANK;
        end else begin
            if (w_wr_en) begin
                r_digits[w_wr_idx] <= data;
            end

            r_presc <= w_tick ? '0 : r_presc + 1'b1;

            // Tick samples pre-edge digit state, so a colliding write shows next frame.
            if (w_tick) begin
                r_anode    <= ~(DIGITS'(1) << r_index);
                r_segments <= w_blank[r_index] ? SEG_BLANK : w_dec_seg;
                r_index    <= (r_index == c_IDX_MAX) ? '0 : r_index + 1'b1;
            end
        end
    end

    assign indicator = r_digits;
    assign anode     = r_anode;
    assign segments  = r_segments;

endmodule
`default_nettype wire

// File: tb/tb_indicator_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_indicator_scanner
//  Description : Directed self-checking bench for indicator_scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_indicator_scanner;

    logic        clock = 1'b0;
    logic        reset;
    logic        rw;
    logic [3:0]  data;
    logic [2:0]  port_id;
    logic        blank_lz;
    logic [15:0] indicator;
    logic [3:0]  anode;
    logic [6:0]  segments;

    int checks = 0;
    int errors = 0;

    indicator_scanner #(
        .DIGITS     (4),
        .DATA_WIDTH (4),
        .PORT_WIDTH (3),
        .SCAN_DIV   (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rw        (rw),
        .data      (data),
        .port_id   (port_id),
        .blank_lz  (blank_lz),
        .indicator (indicator),
        .anode     (anode),
        .segments  (segments)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic write_digit(input logic [2:0] port, input logic [3:0] value);
        rw      = 1'b1;
        port_id = port;
        data    = value;
        step();
        rw      = 1'b0;
    endtask

    // Advance until the edge on which anode switches to the given slot.
    task automatic wait_slot(input string tag, input logic [3:0] exp);
        logic [3:0] prev;
        logic       found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            prev = anode;
            step();
            if (anode == exp && prev != exp) found = 1'b1;
        end
        check_val(tag, 32'(found), 32'd1);
    endtask

    initial begin
        reset    = 1'b1;
        rw       = 1'b0;
        data     = 4'h0;
        port_id  = 3'd0;
        blank_lz = 1'b0;

        // Reset state and first tick
        step(3);
        check_val("rst_indicator", 32'(indicator), 32'h0000);
        check_val("rst_anode", 32'(anode), 32'hF);
        check_val("rst_segments", 32'(segments), 32'h7F);
        reset = 1'b0;
        step(3);
        check_val("pre_tick_anode", 32'(anode), 32'hF);
        step();
        check_val("first_tick_anode", 32'(anode), 32'hE);
        check_val("first_tick_seg", 32'(segments), 32'h40);

        // Writes and one full frame
        write_digit(3'd2, 4'h3);
        check_val("wr_p2", 32'(indicator), 32'h0300);
        write_digit(3'd0, 4'hA);
        check_val("wr_p0", 32'(indicator), 32'h030A);
        wait_slot("slot0_reach", 4'hE);
        check_val("frame_d0", 32'(segments), 32'h08);
        step(3);
        check_val("hold_d0", 32'(anode), 32'hE);
        step();
        check_val("frame_d1_an", 32'(anode), 32'hD);
        check_val("frame_d1", 32'(segments), 32'h40);
        step(4);
        check_val("frame_d2_an", 32'(anode), 32'hB);
        check_val("frame_d2", 32'(segments), 32'h30);
        step(4);
        check_val("frame_d3_an", 32'(anode), 32'h7);
        check_val("frame_d3", 32'(segments), 32'h40);

        // Leading-zero blanking
        write_digit(3'd0, 4'h0);
        write_digit(3'd2, 4'h0);
        write_digit(3'd1, 4'h5);
        check_val("lz_indicator", 32'(indicator), 32'h0050);
        blank_lz = 1'b1;
        wait_slot("lz_d3_reach", 4'h7);
        check_val("lz_d3", 32'(segments), 32'h7F);
        step(4);
        check_val("lz_d0_an", 32'(anode), 32'hE);
        check_val("lz_d0", 32'(segments), 32'h40);
        step(4);
        check_val("lz_d1_an", 32'(anode), 32'hD);
        check_val("lz_d1", 32'(segments), 32'h12);
        step(4);
        check_val("lz_d2_an", 32'(anode), 32'hB);
        check_val("lz_d2", 32'(segments), 32'h7F);
        blank_lz = 1'b0;
        wait_slot("nolz_d3_reach", 4'h7);
        check_val("nolz_d3", 32'(segments), 32'h40);
        wait_slot("nolz_d2_reach", 4'hB);
        check_val("nolz_d2", 32'(segments), 32'h40);

        // Out-of-range port
        write_digit(3'd5, 4'hF);
        check_val("oor_indicator", 32'(indicator), 32'h0050);
        check_val("oor_anode_onehot", 32'($countones(~anode)), 32'd1);

        // Write colliding with digit 1 tick
        wait_slot("coll_d0_reach", 4'hE);
        step(3);
        write_digit(3'd1, 4'h8);
        check_val("coll_anode", 32'(anode), 32'hD);
        check_val("coll_old_seg", 32'(segments), 32'h12);
        check_val("coll_indicator", 32'(indicator), 32'h0080);
        wait_slot("coll_next_reach", 4'hD);
        check_val("coll_new_seg", 32'(segments), 32'h00);

        // Reset mid-scan with simultaneous write
        step();
        reset   = 1'b1;
        rw      = 1'b1;
        port_id = 3'd3;
        data    = 4'h9;
        step();
        reset   = 1'b0;
        rw      = 1'b0;
        check_val("mid_rst_anode", 32'(anode), 32'hF);
        check_val("mid_rst_seg", 32'(segments), 32'h7F);
        check_val("mid_rst_indicator", 32'(indicator), 32'h0000);
        step(3);
        check_val("mid_rst_wait_anode", 32'(anode), 32'hF);
        step();
        check_val("mid_rst_restart_an", 32'(anode), 32'hE);
        check_val("mid_rst_restart_seg", 32'(segments), 32'h40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
